// File: rtl/fir_sample_streamer_if.sv
// Sample stream from the streamer to the FIR filter input, carried over a valid/ready handshake.
interface fir_sample_streamer_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] x_out;
  logic                    x_valid;
  logic                    x_ready;

  modport master (output x_out, x_valid, input x_ready);
  modport slave  (input x_out, x_valid, output x_ready);
endinterface

// File: rtl/fir_sample_streamer.sv
// Replays up to DEPTH host-written samples onto the FIR input (valid/ready) and counts active/stall cycles.
// Define FIR_STREAMER_FLUSH_EN to append HOLD_CYCLES zero beats after the data.
module fir_sample_streamer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
`ifdef FIR_STREAMER_FLUSH_EN
  , parameter int HOLD_CYCLES = 10
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W:0]          num_samples,
  input  logic                     start,
  fir_sample_streamer_if.master    stream,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              cycle_count,
  output logic [31:0]              stall_count
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_N   = 1;
  localparam logic [ADDR_W-1:0] ONE_I   = 1;

  state_t                  state;
  logic [ADDR_W-1:0]       idx;
  logic [ADDR_W:0]         n;
  logic signed [WIDTH-1:0] x_out_q;
  logic                    x_valid_q;
  logic signed [WIDTH-1:0] mem [DEPTH];

`ifdef FIR_STREAMER_FLUSH_EN
  localparam int FW = $clog2(HOLD_CYCLES + 1);
  logic [FW-1:0] flush_cnt;
`endif

  assign stream.x_out   = x_out_q;
  assign stream.x_valid = x_valid_q;

  // Buffer survives reset; host writes only land while idle.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      n           <= '0;
      x_out_q     <= '0;
      x_valid_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      stall_count <= '0;
`ifdef FIR_STREAMER_FLUSH_EN
      flush_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n           <= (num_samples > DEPTH_N) ? DEPTH_N : num_samples;
            idx         <= '0;
            cycle_count <= '0;
            stall_count <= '0;
            busy        <= 1'b1;
            if (num_samples == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= STREAM;
              x_valid_q <= 1'b1;
              // Same-cycle write to entry 0 must be seen by the first beat.
              x_out_q   <= (wr_en && wr_addr == '0) ? wr_data : mem[0];
            end
          end
        end
        STREAM: begin
          cycle_count <= cycle_count + 32'd1;
          if (!stream.x_ready) begin
            stall_count <= stall_count + 32'd1;
          end else if (({1'b0, idx} + ONE_N) < n) begin
            idx     <= idx + ONE_I;
            x_out_q <= mem[idx + ONE_I];
          end else begin
            x_out_q <= '0;
`ifdef FIR_STREAMER_FLUSH_EN
            state     <= FLUSH;
            flush_cnt <= '0;
`else
            state     <= DONE;
            x_valid_q <= 1'b0;
            done      <= 1'b1;
`endif
          end
        end
`ifdef FIR_STREAMER_FLUSH_EN
        FLUSH: begin
          if (stream.x_ready) begin
            if (flush_cnt == FW'(HOLD_CYCLES - 1)) begin
              state     <= DONE;
              x_valid_q <= 1'b0;
              done      <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          x_valid_q <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_streamer.sv
// Directed bench for fir_sample_streamer: reset, streaming, backpressure, clamp, busy protection, sign.
`timescale 1ns/1ps
module tb_fir_sample_streamer;
`ifdef FIR_STREAMER_FLUSH_EN
  localparam int FLUSH_N = 10;
`else
  localparam int FLUSH_N = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               wr_en = 1'b0;
  logic               start = 1'b0;
  logic [6:0]         wr_addr = '0;
  logic signed [15:0] wr_data = '0;
  logic [7:0]         num_samples = '0;
  logic               busy, done;
  logic [31:0]        cycle_count, stall_count;

  fir_sample_streamer_if #(.WIDTH(16)) sif ();

  fir_sample_streamer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_samples(num_samples), .start(start), .stream(sif), .busy(busy), .done(done),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic signed [15:0] got[$];
  int exp_q[$];
  int done_at;
  int hold_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(expv), expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 7'(addr); wr_data = 16'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic begin_run(input int n);
    num_samples = 8'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,1,0...  poke: try start/write while busy.
  task automatic collect(input int mode, input bit poke);
    logic pv, pr;
    logic signed [15:0] px;
    got.delete(); done_at = -1; hold_err = 0; pv = 1'b0; pr = 1'b1; px = '0;
    for (int k = 0; k < 400; k++) begin
      if (pv && !pr && (sif.x_valid !== 1'b1 || sif.x_out !== px)) hold_err++;
      if (done === 1'b1) begin done_at = k; break; end
      sif.x_ready = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      if (poke) begin
        start = (k < 3); wr_en = (k < 3); wr_addr = 7'd2; wr_data = 16'sh1234;
      end
      pv = sif.x_valid; pr = sif.x_ready; px = sif.x_out;
      if (sif.x_valid === 1'b1 && sif.x_ready) got.push_back(sif.x_out);
      tick();
    end
    start = 1'b0; wr_en = 1'b0; sif.x_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input int cyc, input int stl, input int dn);
    for (int i = 0; i < FLUSH_N; i++) exp_q.push_back(0);
    chk({tag, ".beats"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s.beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, ".done_at"}, done_at, dn);
    chk({tag, ".cycle_count"}, cycle_count, cyc);
    chk({tag, ".stall_count"}, stall_count, stl);
    chk({tag, ".hold_violations"}, hold_err, 0);
    chk({tag, ".busy_with_done"}, busy, 1);
    tick();
    chk({tag, ".done_pulse_end"}, done, 0);
    chk({tag, ".busy_end"}, busy, 0);
  endtask

  initial begin
    sif.x_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    chk("rst.x_out", sif.x_out, 0);
    chk("rst.x_valid", sif.x_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cycle_count", cycle_count, 0);
    chk("rst.stall_count", stall_count, 0);

    for (int i = 0; i < 128; i++) wr(i, 10000 + i - 50);

    // Basic 100-sample stream
    begin_run(100);
    chk("basic.first_valid", sif.x_valid, 1);
    chk("basic.first_data", sif.x_out, 9950);
    chk("basic.busy", busy, 1);
    collect(0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back(9950 + i);
    verify("basic", 100, 0, 100 + FLUSH_N);

    // Clamp to DEPTH
    begin_run(200);
    collect(0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(9950 + i);
    verify("clamp", 128, 0, 128 + FLUSH_N);

    // Zero-length run
    begin_run(0);
    chk("zero.done", done, 1);
    chk("zero.x_valid", sif.x_valid, 0);
    chk("zero.busy", busy, 1);
    chk("zero.cycle_count", cycle_count, 0);
    tick();
    chk("zero.done_end", done, 0);
    chk("zero.busy_end", busy, 0);
    chk("zero.x_valid_end", sif.x_valid, 0);

    // Backpressure with alternating ready
    wr(0, 7); wr(1, -3); wr(2, 1000); wr(3, -2000);
    begin_run(4);
    collect(1, 1'b0);
    exp_q = '{7, -3, 1000, -2000};
    verify("bp", 7, 3, 7 + 2 * FLUSH_N);

    // Start/write while busy must not disturb the run or the buffer
    begin_run(4);
    collect(0, 1'b1);
    exp_q = '{7, -3, 1000, -2000};
    verify("busyprot", 4, 0, 4 + FLUSH_N);
    begin_run(4);
    collect(0, 1'b0);
    exp_q = '{7, -3, 1000, -2000};
    verify("busyprot_mem", 4, 0, 4 + FLUSH_N);

    // Extreme signed values
    wr(0, -32768); wr(1, 32767);
    begin_run(2);
    collect(0, 1'b0);
    exp_q = '{-32768, 32767};
    verify("neg", 2, 0, 2 + FLUSH_N);

    // Write to entry 0 in the same cycle as start
    wr_en = 1'b1; wr_addr = 7'd0; wr_data = 16'sh0555;
    begin_run(1);
    wr_en = 1'b0;
    chk("bypass.x_out", sif.x_out, 32'h555);
    chk("bypass.x_valid", sif.x_valid, 1);
    collect(0, 1'b0);
    exp_q = '{32'h555};
    verify("bypass", 1, 0, 1 + FLUSH_N);

    // Reset mid-stream, then confirm the buffer survived
    begin_run(10);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("midrst.x_out", sif.x_out, 0);
    chk("midrst.x_valid", sif.x_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.cycle_count", cycle_count, 0);
    chk("midrst.stall_count", stall_count, 0);
    rst = 1'b1;
    tick();
    begin_run(10);
    collect(0, 1'b0);
    exp_q = '{32'h555, 32767, 1000, -2000, 9954, 9955, 9956, 9957, 9958, 9959};
    verify("midrst_rerun", 10, 0, 10 + FLUSH_N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
